mem_block_responder: RTL and testbench

MEM_BLOCK_RESPONDER -- requirements
Module: mem_block_responder

---
 rtl/mem_block_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_block_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_block_responder
// Description : Behavioural block-memory responder for a cache controller.
//               Accepts one block request per rising edge of mem_req_enable.
//               It answers LATENCY cycles later with a one-cycle ready pulse.
//               Reads return the stored block, and writes commit the captured
//               block at the end of the ready cycle.
//               Storage powers up as a simulation preset pattern:
//               word w of block b reads as {b[15:0], w[15:0]}.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : WORD_SIZE        address width (bits)
//               BLOCK_DATA_WIDTH block width (bits, 32-bit words)
//               BLOCK_OFFSET     word-select address bits
//               DEPTH_BITS       log2 of the number of stored blocks
//               LATENCY          accept-to-ready cycles, 1..15
// Ports       : clk              rising-edge clock
//               rst              synchronous active-high reset
//               mem_req_enable   request strobe (rising edge starts request)
//               mem_req_rw       1 = block write-back, 0 = block refill read
//               mem_req_addr     byte address
//               mem_req_dataout  write-back block from the controller
//               mem_req_datain   refill block to the controller
//               mem_req_ready    one-cycle completion pulse
//               mem_req_error    (MEM_RANGE_CHECK_EN only) out-of-range access
// Macro       : MEM_RANGE_CHECK_EN - when defined, nonzero address bits above
//               the index field flag mem_req_error, suppress writes and zero
//               read data. When undefined those bits alias.
// ============================================================================
module mem_block_responder #(
    parameter int WORD_SIZE        = 32,
    parameter int BLOCK_DATA_WIDTH = 512,
    parameter int BLOCK_OFFSET     = 4,
    parameter int DEPTH_BITS       = 8,
    parameter int LATENCY          = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_req_enable,
    input  logic                        mem_req_rw,
    input  logic [WORD_SIZE-1:0]        mem_req_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout,
    output logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain,
    output logic                        mem_req_ready
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic                        mem_req_error
`endif
);

    localparam int         c_DEPTH   = 1 << DEPTH_BITS;
    localparam int         c_WORDS   = BLOCK_DATA_WIDTH / 32;
    localparam int         c_IDX_LSB = BLOCK_OFFSET + 2;
    localparam int         c_HI_LSB  = c_IDX_LSB + DEPTH_BITS;
    localparam logic [3:0] c_LAT_M1  = 4'(LATENCY - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY    = 2'd1;
    localparam logic [1:0] c_RESPOND = 2'd2;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]                  r_state;
    logic [3:0]                  r_cnt;
    logic                        r_en_d;
    logic                        r_ready;
    logic [BLOCK_DATA_WIDTH-1:0] r_datain;
    logic                        r_rw;
    logic [DEPTH_BITS-1:0]       r_idx;
    logic [BLOCK_DATA_WIDTH-1:0] r_wdata;
    logic                        r_err;
`ifdef MEM_RANGE_CHECK_EN
    logic                        r_error;
`endif

    // Block storage. A block that has never been written reads back as the
    // preset pattern. r_written therefore starts all-clear at time zero.
    // It is deliberately excluded from reset, so reset leaves contents intact.
    logic [BLOCK_DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [c_DEPTH-1:0]          r_written = '0;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic                        w_accept;
    logic                        w_addr_err;
    logic                        w_to_respond;
    logic                        w_fin_rw;
    logic [DEPTH_BITS-1:0]       w_fin_idx;
    logic                        w_fin_err;
    logic [BLOCK_DATA_WIDTH-1:0] w_rd_data;
    logic                        w_commit;
    logic                        w_unused_addr;

    function automatic logic [BLOCK_DATA_WIDTH-1:0] f_preset(
        input logic [DEPTH_BITS-1:0] b
    );
        logic [BLOCK_DATA_WIDTH-1:0] v;
        v = '0;
        for (int w = 0; w < c_WORDS; w++) begin
            v[w*32 +: 32] = {16'(b), 16'(w)};
        end
        return v;
    endfunction

    // Byte/word offset bits (and upper bits when aliasing) carry no meaning.
    assign w_unused_addr = ^mem_req_addr;

`ifdef MEM_RANGE_CHECK_EN
    generate
        if (c_HI_LSB < WORD_SIZE) begin : g_hi_bits
            assign w_addr_err = |mem_req_addr[WORD_SIZE-1:c_HI_LSB];
        end else begin : g_no_hi_bits
            assign w_addr_err = 1'b0;
        end
    endgenerate
`else
    assign w_addr_err = 1'b0;
`endif

    // Rising-edge detect on the strobe. A level held high never re-triggers.
    assign w_accept = (r_state == c_IDLE) && mem_req_enable && !r_en_d;

    // With LATENCY=1, the response is produced straight from IDLE.
    // The request fields therefore come from the live inputs instead of the
    // capture registers, which do not yet hold them.
    assign w_to_respond = (w_accept && (LATENCY == 1)) ||
                          ((r_state == c_BUSY) && (r_cnt == c_LAT_M1));

    assign w_fin_rw  = (r_state == c_IDLE) ? mem_req_rw : r_rw;
    assign w_fin_idx = (r_state == c_IDLE) ? mem_req_addr[c_IDX_LSB +: DEPTH_BITS] : r_idx;
    assign w_fin_err = (r_state == c_IDLE) ? w_addr_err : r_err;

    assign w_rd_data = r_written[w_fin_idx] ? r_mem[w_fin_idx] : f_preset(w_fin_idx);

    // A write lands at the close of the ready cycle.
    // Reset at that edge cancels it.
    assign w_commit = (r_state == c_RESPOND) && r_rw && !r_err && !rst;

    // ------------------------------------------------------------------
    // Storage write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_idx]     <= r_wdata;
            r_written[r_idx] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Request FSM and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= 4'd0;
            r_en_d   <= 1'b0;
            r_ready  <= 1'b0;
            r_datain <= '0;
            r_rw     <= 1'b0;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            r_error  <= 1'b0;
`endif
        end else begin
            r_en_d  <= mem_req_enable;
            r_ready <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            r_error <= 1'b0;
`endif

            if (w_accept) begin
                r_rw    <= mem_req_rw;
                r_idx   <= mem_req_addr[c_IDX_LSB +: DEPTH_BITS];
                r_wdata <= mem_req_dataout;
                r_err   <= w_addr_err;
            end

            if (w_to_respond) begin
                r_ready <= 1'b1;
`ifdef MEM_RANGE_CHECK_EN
                r_error <= w_fin_err;
`endif
                // Write responses leave the refill data untouched.
                if (!w_fin_rw) begin
                    r_datain <= w_fin_err ? '0 : w_rd_data;
                end
            end

            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (LATENCY == 1) begin
                            r_state <= c_RESPOND;
                        end else begin
                            r_state <= c_BUSY;
                            // Counting starts at 1, so that LATENCY-1 marks
                            // the last BUSY cycle.
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                c_BUSY: begin
                    if (r_cnt == c_LAT_M1) begin
                        r_state <= c_RESPOND;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                c_RESPOND: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign mem_req_datain = r_datain;
    assign mem_req_ready  = r_ready;
`ifdef MEM_RANGE_CHECK_EN
    assign mem_req_error  = r_error;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_block_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_block_responder
// Description : Randomized self-checking bench for mem_block_responder.
//               The reference model is a plain array of blocks.
//               A second instance runs with LATENCY=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_block_responder;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, rw;
    logic [31:0]  addr;
    logic [511:0] dout;
    logic [511:0] din;
    logic         rdy;

    logic         en1, rw1;
    logic [31:0]  addr1;
    logic [511:0] dout1;
    logic [511:0] din1;
    logic         rdy1;
`ifdef MEM_RANGE_CHECK_EN
    logic         err;
    logic         err1;
`endif

    always #5 clk = ~clk;

    mem_block_responder #(.LATENCY(LAT)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_enable  (en),
        .mem_req_rw      (rw),
        .mem_req_addr    (addr),
        .mem_req_dataout (dout),
        .mem_req_datain  (din),
        .mem_req_ready   (rdy)
`ifdef MEM_RANGE_CHECK_EN
        ,
        .mem_req_error   (err)
`endif
    );

    mem_block_responder #(.LATENCY(1)) u_lat1 (
        .clk             (clk),
        .rst             (rst),
        .mem_req_enable  (en1),
        .mem_req_rw      (rw1),
        .mem_req_addr    (addr1),
        .mem_req_dataout (dout1),
        .mem_req_datain  (din1),
        .mem_req_ready   (rdy1)
`ifdef MEM_RANGE_CHECK_EN
        ,
        .mem_req_error   (err1)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [511:0] model_mem [0:255];
    logic [511:0] model_din;

    function automatic logic [511:0] preset_blk(input int b);
        logic [511:0] v;
        v = '0;
        for (int w = 0; w < 16; w++) v[w*32 +: 32] = 32'(b * 65536 + w);
        return v;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 6) % 256);
    endfunction

    function automatic bit range_err(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
        return (a >> 14) != 0;
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    // A single request: enable rises for one cycle.
    // Afterwards the inputs are scrambled; the captured values must win.
    task automatic transact(input bit t_rw, input logic [31:0] t_addr,
                            input logic [511:0] t_data, input string tag);
        int           k;
        int           b;
        bit           e;
        logic [511:0] exp_din;
        b = idx_of(t_addr);
        e = range_err(t_addr);
        exp_din = t_rw ? model_din : (e ? 512'd0 : model_mem[b]);
        @(posedge clk); #1;
        en = 1'b1; rw = t_rw; addr = t_addr; dout = t_data;
        for (k = 1; k <= LAT + 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                en   = 1'b0;
                rw   = 1'($urandom);
                addr = $urandom;
                dout = {16{$urandom}};
            end
            if (rdy) break;
        end
        check({tag, " latency"}, 512'(k), 512'(LAT));
        check({tag, " datain"}, din, exp_din);
`ifdef MEM_RANGE_CHECK_EN
        check({tag, " error"}, 512'(err), 512'(e));
`endif
        if (t_rw && !e) model_mem[b] = t_data;
        if (!t_rw) model_din = exp_din;
        @(posedge clk); #1;
        check({tag, " ready low"}, 512'(rdy), 512'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int           k;
        int           pulses;
        logic [511:0] wd;
        logic [31:0]  a;

        for (int b = 0; b < 256; b++) model_mem[b] = preset_blk(b);
        model_din = '0;
        rst = 1'b1; en = 1'b0; rw = 1'b0; addr = '0; dout = '0;
        en1 = 1'b0; rw1 = 1'b0; addr1 = '0; dout1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 512'(rdy), 512'd0);
        check("reset datain", din, 512'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Read block 3: known preset words.
        transact(1'b0, 32'h0000_00C0, '0, "read blk3");
        check("blk3 word0", 512'(din[31:0]), 512'(32'h0003_0000));
        check("blk3 word15", 512'(din[511:480]), 512'(32'h0003_000F));

        // Write block 5 with DEADBEEF+i, then read it straight back.
        for (int i = 0; i < 16; i++) wd[i*32 +: 32] = 32'hDEADBEEF + 32'(i);
        transact(1'b1, 32'h0000_0140, wd, "write blk5");
        transact(1'b0, 32'h0000_0144, '0, "read blk5");
        check("blk5 word2", 512'(din[95:64]), 512'(32'hDEADBEF1));

        // Enable held high for 20 cycles yields a single ready pulse.
        @(posedge clk); #1;
        en = 1'b1; rw = 1'b0; addr = 32'h0000_0240;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (rdy) pulses++;
        end
        en = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(posedge clk); #1;
            if (rdy) pulses++;
        end
        check("held enable pulses", 512'(pulses), 512'd1);
        check("held enable datain", din, model_mem[9]);
        model_din = model_mem[9];

        // Reset two cycles after accepting a write to block 7 aborts it.
        @(posedge clk); #1;
        en = 1'b1; rw = 1'b1; addr = 32'h0000_01C0; dout = {16{32'h1234_5678}};
        pulses = 0;
        @(posedge clk); #1;
        en = 1'b0;
        if (rdy) pulses++;
        @(posedge clk); #1;
        if (rdy) pulses++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < LAT + 3; c++) begin
            @(posedge clk); #1;
            if (rdy) pulses++;
        end
        check("aborted write ready", 512'(pulses), 512'd0);
        check("datain after reset", din, 512'd0);
        model_din = '0;
        transact(1'b0, 32'h0000_01C0, '0, "read blk7 after abort");

        // Enable already high while reset deasserts: accepted on the first cycle.
        @(posedge clk); #1;
        rst = 1'b1; en = 1'b1; rw = 1'b0; addr = 32'h0000_0080;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (k = 1; k <= LAT + 4; k++) begin
            @(posedge clk); #1;
            if (rdy) break;
        end
        en = 1'b0;
        check("accept out of reset latency", 512'(k), 512'(LAT));
        check("accept out of reset datain", din, model_mem[2]);
        model_din = model_mem[2];
        @(posedge clk); #1;

        // Out-of-range write: aliases to block 0, or flags an error and is dropped.
        wd = {16{32'hA5A5_0000}};
        transact(1'b1, 32'h0001_0000, wd, "high-addr write");
        transact(1'b0, 32'h0000_0000, '0, "read blk0");
`ifdef MEM_RANGE_CHECK_EN
        check("blk0 unchanged", din, preset_blk(0));
`else
        check("blk0 aliased", din, wd);
`endif

        // Randomized traffic over a small set of blocks.
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 15)) << 6;
            a = a | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 255)) << 14);
            transact(1'($urandom), a, {16{$urandom}}, $sformatf("rand%0d", i));
        end

        // LATENCY=1: write then read back, separated by one low enable cycle.
        wd = {16{$urandom}};
        @(posedge clk); #1;
        en1 = 1'b1; rw1 = 1'b1; addr1 = 32'h0000_0080; dout1 = wd;
        @(posedge clk); #1;
        check("lat1 write ready", 512'(rdy1), 512'd1);
        en1 = 1'b0;
        @(posedge clk); #1;
        check("lat1 gap ready", 512'(rdy1), 512'd0);
        en1 = 1'b1; rw1 = 1'b0;
        @(posedge clk); #1;
        check("lat1 read ready", 512'(rdy1), 512'd1);
        check("lat1 read datain", din1, wd);
        en1 = 1'b0;
        @(posedge clk); #1;
        check("lat1 ready low", 512'(rdy1), 512'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
